// File: rtl/risc15_pkg.sv
// Shared widths and sequencer state encoding for the multi-word LM/SM data-memory port.
package risc15_pkg;

   localparam int WORD_W    = 16;
   localparam int REG_IDX_W = 3;
   localparam int MASK_W    = 8;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_XFER = 2'd1,
      SEQ_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/lowest_set_bit_enc.sv
// Priority encoder returning the index of the lowest set bit, plus a flag for a non-zero mask.
module lowest_set_bit_enc #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     mask_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   // Walk from the top down so the lowest set bit is the last one to win.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o   = i[IDX_W-1:0];
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_multi_xfer_seq.sv
// LM/SM sequencer: one memory word transfer per set mask bit, ascending registers, consecutive addresses.
module mem_multi_xfer_seq
   import risc15_pkg::*;
#(
   parameter int DATA_W = WORD_W,
   parameter int ADDR_W = 16,
   parameter int NREGS  = MASK_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 is_store,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [NREGS-1:0]     reg_mask,
   output logic                 busy,
   output logic                 done,
   output logic                 stall,
   output logic [ADDR_W-1:0]    mem_read_addr,
   input  logic [DATA_W-1:0]    mem_read_data,
   output logic [ADDR_W-1:0]    mem_write_addr,
   output logic [DATA_W-1:0]    mem_write_data,
   output logic                 mem_write_n,
   output logic [REG_IDX_W-1:0] rf_read_idx,
   input  logic [DATA_W-1:0]    rf_read_data,
   output logic [REG_IDX_W-1:0] rf_write_idx,
   output logic [DATA_W-1:0]    rf_write_data,
   output logic                 rf_write_en
);

   seq_state_e           state_q;
   logic [ADDR_W-1:0]    cur_addr_q;
   logic [NREGS-1:0]     rem_mask_q;
   logic [NREGS-1:0]     rem_mask_d;
   logic                 op_store_q;
   logic [REG_IDX_W-1:0] idx;
   logic                 idx_valid;
   logic                 xfer_active;
   logic                 lm_active;
   logic                 sm_active;

   lowest_set_bit_enc #(
      .N     (NREGS),
      .IDX_W (REG_IDX_W)
   ) u_lsb (
      .mask_i  (rem_mask_q),
      .idx_o   (idx),
      .valid_o (idx_valid)
   );

   assign rem_mask_d = rem_mask_q & ~(NREGS'(1) << idx);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= SEQ_IDLE;
         cur_addr_q <= '0;
         rem_mask_q <= '0;
         op_store_q <= 1'b0;
      end else begin
         case (state_q)
            SEQ_IDLE: begin
               if (start) begin
                  cur_addr_q <= base_addr;
                  rem_mask_q <= reg_mask;
                  op_store_q <= is_store;
                  state_q    <= (reg_mask == '0) ? SEQ_DONE : SEQ_XFER;
               end
            end
            SEQ_XFER: begin
               rem_mask_q <= rem_mask_d;
               cur_addr_q <= cur_addr_q + ADDR_W'(1);
               if (rem_mask_d == '0) begin
                  state_q <= SEQ_DONE;
               end
            end
            SEQ_DONE: state_q <= SEQ_IDLE;
            default:  state_q <= SEQ_IDLE;
         endcase
      end
   end

   // Strobes are gated by reset so a transfer caught by a reset edge never commits.
   assign xfer_active = (state_q == SEQ_XFER) && idx_valid && reset;
   assign lm_active   = xfer_active && !op_store_q;
   assign sm_active   = xfer_active && op_store_q;

   assign busy  = (state_q != SEQ_IDLE);
   assign done  = (state_q == SEQ_DONE);
   assign stall = busy || (start && (state_q == SEQ_IDLE));

   assign mem_read_addr  = lm_active ? cur_addr_q    : '0;
   assign rf_write_idx   = lm_active ? idx           : '0;
   assign rf_write_data  = lm_active ? mem_read_data : '0;
   assign rf_write_en    = lm_active;

   assign rf_read_idx    = sm_active ? idx           : '0;
   assign mem_write_addr = sm_active ? cur_addr_q    : '0;
   assign mem_write_data = sm_active ? rf_read_data  : '0;
   assign mem_write_n    = !sm_active;

endmodule

// File: tb/tb_mem_multi_xfer_seq.sv
// Bench for mem_multi_xfer_seq: directed LM/SM scenarios plus random sequences against a mask-walking model.
module tb_mem_multi_xfer_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [15:0] base_addr;
   logic [7:0]  reg_mask;
   logic        busy;
   logic        done;
   logic        stall;
   logic [15:0] mem_read_addr;
   logic [15:0] mem_read_data;
   logic [15:0] mem_write_addr;
   logic [15:0] mem_write_data;
   logic        mem_write_n;
   logic [2:0]  rf_read_idx;
   logic [15:0] rf_read_data;
   logic [2:0]  rf_write_idx;
   logic [15:0] rf_write_data;
   logic        rf_write_en;

   logic [15:0] mem [0:65535];
   logic [15:0] rf  [0:7];
   int          compareCount  = 0;
   int          mismatchCount = 0;

   mem_multi_xfer_seq dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .is_store       (is_store),
      .base_addr      (base_addr),
      .reg_mask       (reg_mask),
      .busy           (busy),
      .done           (done),
      .stall          (stall),
      .mem_read_addr  (mem_read_addr),
      .mem_read_data  (mem_read_data),
      .mem_write_addr (mem_write_addr),
      .mem_write_data (mem_write_data),
      .mem_write_n    (mem_write_n),
      .rf_read_idx    (rf_read_idx),
      .rf_read_data   (rf_read_data),
      .rf_write_idx   (rf_write_idx),
      .rf_write_data  (rf_write_data),
      .rf_write_en    (rf_write_en)
   );

   always #5 clk = ~clk;

   // Data memory and register file environment: async reads, writes on the rising edge.
   assign mem_read_data = mem[mem_read_addr];
   assign rf_read_data  = rf[rf_read_idx];

   always @(posedge clk) begin
      if (!mem_write_n) mem[mem_write_addr] <= mem_write_data;
      if (rf_write_en)  rf[rf_write_idx]    <= rf_write_data;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One LM/SM request; abortCycle pulls reset low during that XFER cycle, restartCycle re-pulses start.
   task automatic applyStimulus(input logic isStore, input logic [15:0] base, input logic [7:0] mask,
                                input int abortCycle, input int restartCycle);
      int          idxQ[$];
      logic [15:0] preMem [8];
      logic [15:0] preRf  [8];
      logic [15:0] addrQ  [8];
      int          n;
      int          lastCycle;
      int          commits;
      logic        xfer;
      idxQ = {};
      for (int i = 0; i < 8; i++) if (mask[i]) idxQ.push_back(i);
      n = idxQ.size();
      for (int j = 0; j < n; j++) begin
         addrQ[j]  = base + 16'(j);
         preMem[j] = mem[addrQ[j]];
      end
      for (int r = 0; r < 8; r++) preRf[r] = rf[r];
      lastCycle = (abortCycle != 0) ? abortCycle : n + 1;
      commits   = (abortCycle != 0) ? abortCycle - 1 : n;

      @(negedge clk);
      start = 1'b1; is_store = isStore; base_addr = base; reg_mask = mask;
      #1;
      checkOutput("stallAtStart", stall, 1);
      checkOutput("busyAtStart", busy, 0);

      for (int k = 1; k <= lastCycle; k++) begin
         @(negedge clk);
         if (k == restartCycle) begin
            start = 1'b1; is_store = ~isStore; reg_mask = ~mask; base_addr = base + 16'h0100;
         end else begin
            start = 1'b0; base_addr = 16'($urandom); reg_mask = 8'($urandom);
         end
         if (k == abortCycle) reset = 1'b0;
         #1;
         xfer = (k <= n) && (k != abortCycle);
         checkOutput("busy", busy, 1);
         checkOutput("stall", stall, 1);
         checkOutput("done", done, (k == n + 1) ? 1 : 0);
         checkOutput("memWriteN", mem_write_n, (xfer && isStore) ? 0 : 1);
         checkOutput("rfWriteEn", rf_write_en, (xfer && !isStore) ? 1 : 0);
         if (xfer && isStore) begin
            checkOutput("memWriteAddr", mem_write_addr, addrQ[k-1]);
            checkOutput("rfReadIdx", rf_read_idx, idxQ[k-1]);
            checkOutput("memWriteData", mem_write_data, preRf[idxQ[k-1]]);
         end
         if (xfer && !isStore) begin
            checkOutput("memReadAddr", mem_read_addr, addrQ[k-1]);
            checkOutput("rfWriteIdx", rf_write_idx, idxQ[k-1]);
            checkOutput("rfWriteData", rf_write_data, preMem[k-1]);
         end
      end

      @(negedge clk);
      reset = 1'b1; start = 1'b0;
      #1;
      checkOutput("busyAfter", busy, 0);
      checkOutput("doneAfter", done, 0);
      checkOutput("stallAfter", stall, 0);
      checkOutput("strobesAfter", {mem_write_n, rf_write_en}, 2'b10);

      for (int j = 0; j < n; j++) begin
         if (isStore)
            checkOutput("memFinal", mem[addrQ[j]], (j < commits) ? preRf[idxQ[j]] : preMem[j]);
         else
            checkOutput("rfFinal", rf[idxQ[j]], (j < commits) ? preMem[j] : preRf[idxQ[j]]);
      end
   endtask

   initial begin
      int n;
      logic [7:0] m;
      for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
      for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
      reset = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0; reg_mask = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstStall", stall, 0);
      checkOutput("rstStrobes", {mem_write_n, rf_write_en}, 2'b10);
      checkOutput("rstAddrs", {mem_read_addr, mem_write_addr}, 32'h0);
      checkOutput("rstIdx", {rf_read_idx, rf_write_idx}, 6'h0);
      reset = 1'b1;

      mem[16'h0010] = 16'h0480; mem[16'h0011] = 16'h0100;
      applyStimulus(1'b0, 16'h0010, 8'b0000_0101, 0, 0);
      checkOutput("t1R0", rf[0], 16'h0480);
      checkOutput("t1R2", rf[2], 16'h0100);

      rf[1] = 16'h0380; rf[2] = 16'h0480;
      applyStimulus(1'b1, 16'h0000, 8'b0000_0110, 0, 0);
      checkOutput("t2Mem0", mem[0], 16'h0380);
      checkOutput("t2Mem1", mem[1], 16'h0480);

      applyStimulus(1'b1, 16'h1234, 8'h00, 0, 0);
      applyStimulus(1'b0, 16'hFFFE, 8'hFF, 0, 0);
      applyStimulus(1'b1, 16'h0000, 8'h0F, 3, 0);
      applyStimulus(1'b0, 16'h0200, 8'b1010_0110, 0, 2);

      for (int t = 0; t < 40; t++) begin
         m = 8'($urandom);
         n = $countones(m);
         applyStimulus(1'($urandom), 16'($urandom),  m,
                       ((t % 5) == 4 && n > 0) ? int'($urandom_range(n, 1)) : 0,
                       ((t % 3) == 1) ? int'($urandom_range(n + 1, 1)) : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
